// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store port.
// Accepts one request at a time through a valid/ready handshake, waits LATENCY
// cycles, performs the access on a word-organised internal array, then presents
// a response that is held until the requester takes it.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   req_valid / req_ready   request handshake
//   req_write               1 = store, 0 = load
//   req_addr                byte address
//   req_wdata / req_be      store data and per-byte enables
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata               load data; 0 for stores and errors
//   rsp_err                 misaligned or out-of-range access
//   busy                    high whenever a transaction is in flight
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   // Latched request; inputs are only sampled on the accept edge
   logic          wr_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;

   logic [31:0]   rdata_nxt;
   logic          err_nxt;
   logic          latch_c;
   logic          mem_we_c;
   logic          addr_err_c;
   logic [AW-1:0] widx_c;

   logic [31:0]   mem [DEPTH_WORDS];

   // Address checks on the latched request
   assign addr_err_c = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
   assign widx_c     = addr_q[AW+1:2];

   // Next-state, counter and response data
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rdata_nxt = rsp_rdata;
      err_nxt   = rsp_err;
      latch_c   = 1'b0;
      mem_we_c  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               latch_c   = 1'b1;
               cnt_nxt   = CW'(LATENCY);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               // Access happens on this edge; errors never touch storage
               state_nxt = RESP;
               err_nxt   = addr_err_c;
               mem_we_c  = wr_q && !addr_err_c;
               rdata_nxt = (!wr_q && !addr_err_c) ? mem[widx_c] : 32'h0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
               rdata_nxt = 32'h0;
               err_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         be_q      <= 4'h0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         busy      <= (state_nxt != IDLE);
         rsp_rdata <= rdata_nxt;
         rsp_err   <= err_nxt;
         if (latch_c) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
      end
   end

   // Storage is not reset; a reset on the access edge discards the pending store
   always_ff @(posedge clk) begin
      if (mem_we_c && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[widx_c][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
